// File: rtl/router_bus_rr_arbiter.sv
// Round-robin arbiter: pops one packet from an eligible port and holds it in a registered output slot.
// One cycle from eligible to out_valid, at most one packet every 2 cycles; the slot holds until out_ready.
module router_bus_rr_arbiter #(
    parameter int PCKG_SZ = 40,
    parameter int N_PORTS = 4,
    parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         port_en,
    input  logic [N_PORTS-1:0]         pndng,
    input  logic [N_PORTS*PCKG_SZ-1:0] data_out,
    output logic [N_PORTS-1:0]         pop,
    output logic                       out_valid,
    output logic [PCKG_SZ-1:0]         out_data,
    output logic [IDX_W-1:0]           out_src,
    input  logic                       out_ready,
    output logic [15:0]                grant_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [N_PORTS-1:0]       pndng_q;
    logic [N_PORTS-1:0]       elig;
    logic [2*N_PORTS-1:0]     elig_dbl;
    logic [N_PORTS-1:0]       elig_rot;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         sel;
    logic                     any_elig;
    int                       offset;
    logic [PCKG_SZ-1:0]       sel_data;
    logic                     take;
    logic                     done;

    // Requiring pending in two consecutive samples guarantees pop only follows a registered pndng.
    assign elig     = pndng & pndng_q & port_en;
    assign elig_dbl = {elig, elig};
    assign elig_rot = N_PORTS'(elig_dbl >> (int'(last_grant) + 1));

    always_comb begin
        any_elig = |elig_rot;
        offset   = 0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                offset = k;
            end
        end
        sel = IDX_W'((int'(last_grant) + 1 + offset) % N_PORTS);
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (IDX_W'(i) == sel) begin
                sel_data = data_out[i*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    assign take = (state == IDLE) && any_elig;
    assign done = (state == SEND) && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_elig)  state_nxt = SEND;
            SEND: if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = '0;
        if (state == IDLE && any_elig) begin
            pop[sel] = 1'b1;
        end
    end

    // A packet held at reset is dropped: its source has already popped it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pndng_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            grant_cnt  <= '0;
            last_grant <= IDX_W'(N_PORTS - 1);
        end else begin
            pndng_q <= pndng;
            if (take) begin
                out_valid  <= 1'b1;
                out_data   <= sel_data;
                out_src    <= sel;
                last_grant <= sel;
            end else if (done) begin
                out_valid <= 1'b0;
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_router_bus_rr_arbiter.sv
// Directed bench for router_bus_rr_arbiter: scoreboard of expected (src, data) per transfer,
// plus a negedge monitor for pop legality, capture, hold stability and grant count.
module tb_router_bus_rr_arbiter;
    localparam int PCKG_SZ = 40;
    localparam int N_PORTS = 4;
    localparam int IDX_W   = 2;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [N_PORTS-1:0]         port_en;
    logic [N_PORTS-1:0]         pndng;
    logic [N_PORTS*PCKG_SZ-1:0] data_out;
    logic [N_PORTS-1:0]         pop;
    logic                       out_valid;
    logic [PCKG_SZ-1:0]         out_data;
    logic [IDX_W-1:0]           out_src;
    logic                       out_ready;
    logic [15:0]                grant_cnt;
    logic [PCKG_SZ-1:0]         pdata [N_PORTS];

    for (genvar g = 0; g < N_PORTS; g++) begin : g_pack
        assign data_out[g*PCKG_SZ +: PCKG_SZ] = pdata[g];
    end

    router_bus_rr_arbiter #(.PCKG_SZ(PCKG_SZ), .N_PORTS(N_PORTS)) dut (
        .clk(clk), .reset(reset), .port_en(port_en), .pndng(pndng), .data_out(data_out),
        .pop(pop), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0]   src;
        logic [PCKG_SZ-1:0] data;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [15:0] tb_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pop_idx(input logic [N_PORTS-1:0] v);
        pop_idx = 0;
        for (int i = N_PORTS - 1; i >= 0; i--) if (v[i]) pop_idx = i;
    endfunction

    task automatic expect_pkt(input int p);
        exp_t e;
        e.src  = IDX_W'(p);
        e.data = pdata[p];
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        chk(tag, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    // Monitor state
    logic [N_PORTS-1:0] prev_pop = '0;
    logic [N_PORTS-1:0] pndng_prev = '0;
    logic [PCKG_SZ-1:0] prev_pop_data = '0;
    logic               prev_hold = 1'b0;
    logic [PCKG_SZ-1:0] hold_data = '0;
    logic [IDX_W-1:0]   hold_src = '0;

    always @(negedge clk) begin
        if (reset) begin
            tb_cnt    = '0;
            prev_pop  = '0;
            prev_hold = 1'b0;
        end else begin
            chk("pop_onehot0", 64'($countones(pop) <= 1), 1);
            if (pop != '0) begin
                chk("pop_past_pndng", pop & ~pndng_prev, 0);
                chk("pop_masked_en", pop & ~port_en, 0);
                chk("pop_in_send", out_valid, 0);
            end
            if (prev_pop != '0) begin
                chk("cap_valid", out_valid, 1);
                chk("cap_src", out_src, pop_idx(prev_pop));
                chk("cap_data", out_data, prev_pop_data);
            end
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hold_data);
                chk("hold_src", out_src, hold_src);
            end
            chk("grant_cnt", grant_cnt, tb_cnt);
            if (out_valid && out_ready) begin
                chk("xfer_expected", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_src", out_src, e.src);
                    chk("sb_data", out_data, e.data);
                end
                tb_cnt = tb_cnt + 16'd1;
            end
            prev_pop      = pop;
            prev_pop_data = pdata[pop_idx(pop)];
            prev_hold     = out_valid && !out_ready;
            hold_data     = out_data;
            hold_src      = out_src;
        end
        pndng_prev = pndng;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        pndng     = '0;
        port_en   = 4'hF;
        out_ready = 1'b1;
        pdata[0]  = 40'hA5;
        pdata[1]  = 40'h11_0000_0001;
        pdata[2]  = 40'h22_0000_0002;
        pdata[3]  = 40'h33_0000_0003;

        // Reset state
        cycles(2);
        chk("rst_pop", pop, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_cnt", grant_cnt, 0);
        reset = 1'b0;

        // Single packet from port 0
        pndng = 4'b0001;
        expect_pkt(0);
        cycles(1);
        chk("t1_pop", pop, 4'b0001);
        cycles(1);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 40'hA5);
        chk("t1_src", out_src, 0);
        chk("t1_pop_send", pop, 0);
        pndng = 4'b0000;
        wait_drain("t1_drain");

        // All ports pending: 0,1,2,3,0,1
        for (int i = 0; i < N_PORTS; i++) pdata[i] = {8'h20 + 8'(i), 32'h1234_5670 + 32'(i)};
        reset_pulse();
        expect_pkt(0); expect_pkt(1); expect_pkt(2); expect_pkt(3); expect_pkt(0); expect_pkt(1);
        pndng = 4'b1111;
        cycles(12);
        pndng = 4'b0000;
        wait_drain("t2_drain");
        chk("t2_cnt", grant_cnt, 6);

        // Wrap-around from last_grant=1 with ports 1 and 3
        expect_pkt(3); expect_pkt(1);
        pndng = 4'b1010;
        cycles(4);
        pndng = 4'b0000;
        wait_drain("t3_drain");

        // Backpressure for 5 cycles
        out_ready = 1'b0;
        pndng = 4'b0001;
        expect_pkt(0);
        cycles(2);
        pndng = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            chk("t4_valid", out_valid, 1);
            chk("t4_data", out_data, pdata[0]);
            chk("t4_pop", pop, 0);
        end
        out_ready = 1'b1;
        cycles(1);
        chk("t4_done", out_valid, 0);
        chk("t4_cnt", grant_cnt, 9);
        wait_drain("t4_drain");

        // Port 1 masked: 0,2,3,0
        reset_pulse();
        port_en = 4'b1101;
        expect_pkt(0); expect_pkt(2); expect_pkt(3); expect_pkt(0);
        pndng = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            chk("t5_no_pop1", pop[1], 0);
        end
        pndng = 4'b0000;
        wait_drain("t5_drain");
        port_en = 4'hF;

        // Reset while a packet sits in the slot
        out_ready = 1'b0;
        pndng = 4'b0100;
        cycles(2);
        chk("t6_held", out_valid, 1);
        chk("t6_held_src", out_src, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_pop", pop, 0);
        chk("t6_rst_cnt", grant_cnt, 0);
        out_ready = 1'b1;
        pndng = 4'b0101;
        expect_pkt(0); expect_pkt(2);
        cycles(1);
        chk("t6_rst_pop2", pop, 0);
        reset = 1'b0;
        cycles(4);
        pndng = 4'b0000;
        wait_drain("t6_drain");
        chk("t6_cnt", grant_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
